// File: rtl/wb_master_seq_if.sv
// Command, response and Wishbone initiator signals of wb_master_seq in one bundle.
// The master modport is the sequencer's view; slave is the view of whatever surrounds it.
interface wb_master_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat;
  logic [SEL_W-1:0]  cmd_sel;
  logic [3:0]        cmd_len;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;
  logic              rsp_last;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [SEL_W-1:0]  wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_len,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err, rsp_last,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, cmd_len,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err, rsp_last,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: one command becomes 1..16 single-beat transfers at consecutive words.
// state | meaning -- IDLE: accept command | BUS: stb high, waiting ack | RSP: response held until rsp_ready
module wb_master_seq #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_master_seq_if.master bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [3:0]        r_len;
  logic [3:0]        r_beat;
  logic [15:0]       r_tmo;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_dat;
  logic              r_rsp_err;
  logic              r_rsp_last;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_we        <= bus.cmd_we;
            r_adr       <= bus.cmd_adr;
            r_dat       <= bus.cmd_dat;
            r_sel       <= bus.cmd_sel;
            r_len       <= bus.cmd_len;
            r_beat      <= '0;
            r_tmo       <= '0;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= S_BUS;
          end
        end
        S_BUS: begin
          // An ack arriving on the expiry cycle still wins over the timeout.
          if (bus.wbm_ack_i) begin
            r_rsp_dat   <= r_we ? '0 : bus.wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= (r_beat == r_len);
            r_rsp_valid <= 1'b1;
            r_stb       <= 1'b0;
            r_state     <= S_RSP;
          end else if (r_tmo == TMO_LAST) begin
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_stb       <= 1'b0;
            r_cyc       <= 1'b0;
            r_state     <= S_RSP;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_last) begin
              r_cyc       <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_adr   <= r_adr + ADDR_W'(4);
              r_beat  <= r_beat + 4'd1;
              r_tmo   <= '0;
              r_stb   <= 1'b1;
              r_state <= S_BUS;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_stb;
  assign bus.wbm_we_o  = r_we;
  assign bus.wbm_sel_o = r_sel;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;
endmodule

// File: tb/tb_wb_master_seq.sv
// Scoreboard bench for wb_master_seq: commands push expected beats/responses, a slave model
// and a response monitor pop and compare independently.
module tb_wb_master_seq;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          delay;
    logic [31:0] rdat;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_master_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  wb_master_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  rsp_t  exp_q[$];
  beat_t beat_q[$];
  int checks = 0;
  int failures = 0;
  int ready_pct = 100;
  int beats_started = 0;
  int          tb_delay[16];
  logic [31:0] tb_rdat[16];

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected behaviour from the command alone: beats at adr+4*i until len or the first beat
  // whose slave delay reaches TIMEOUT, which ends the command with an error response.
  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [3:0] len);
    beat_t b;
    rsp_t  r;
    int    n;
    for (int i = 0; i <= int'(len); i++) begin
      b.adr = adr + 32'(4 * i);
      b.we = we;
      b.sel = sel;
      b.wdat = dat;
      b.delay = tb_delay[i];
      b.rdat = tb_rdat[i];
      beat_q.push_back(b);
      if (tb_delay[i] >= TIMEOUT) begin
        r.dat = 32'h0;
        r.err = 1'b1;
        r.last = 1'b1;
        exp_q.push_back(r);
        break;
      end
      r.dat = we ? 32'h0 : tb_rdat[i];
      r.err = 1'b0;
      r.last = (i == int'(len));
      exp_q.push_back(r);
    end
    n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_wait actual=0 required=1 at %0t", $time);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_we = we;
    bus.cmd_adr = adr;
    bus.cmd_dat = dat;
    bus.cmd_sel = sel;
    bus.cmd_len = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'($urandom);
    bus.cmd_adr = $urandom;
    bus.cmd_dat = $urandom;
    bus.cmd_sel = 4'($urandom);
    bus.cmd_len = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check32("idle_reached", 32'(n < 3000), 32'd1);
    check32("beats_left", 32'(beat_q.size()), 32'd0);
    check32("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic rand_beats(input int tmo_pct);
    for (int i = 0; i < 16; i++) begin
      tb_rdat[i] = $urandom;
      if ($urandom_range(0, 99) < tmo_pct) tb_delay[i] = $urandom_range(TIMEOUT, TIMEOUT + 3);
      else if ($urandom_range(0, 9) == 0) tb_delay[i] = TIMEOUT - 1;
      else tb_delay[i] = $urandom_range(0, 4);
    end
  endtask

  // Slave model: acks a beat after its scheduled delay, checks the bus fields and stb width,
  // and throws spurious acks while stb is low.
  initial begin : slave
    beat_t cur;
    int    scnt;
    bit    active;
    active = 1'b0;
    scnt = 0;
    cur.delay = 1000;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        scnt = 0;
        bus.wbm_ack_i = 1'b0;
      end else if (bus.wbm_stb_o) begin
        if (!active) begin
          beats_started++;
          if (beat_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_stb actual=adr_%h required=no_beat at %0t", bus.wbm_adr_o, $time);
            cur.delay = 1000;
          end else begin
            cur = beat_q.pop_front();
            check32("wb_adr", bus.wbm_adr_o, cur.adr);
            check32("wb_we", 32'(bus.wbm_we_o), 32'(cur.we));
            check32("wb_sel", 32'(bus.wbm_sel_o), 32'(cur.sel));
            if (cur.we) check32("wb_dat_o", bus.wbm_dat_o, cur.wdat);
          end
          check32("cyc_with_stb", 32'(bus.wbm_cyc_o), 32'd1);
          active = 1'b1;
          scnt = 0;
        end
        if (scnt == cur.delay) begin
          bus.wbm_ack_i = 1'b1;
          bus.wbm_dat_i = cur.rdat;
        end else begin
          bus.wbm_ack_i = 1'b0;
          bus.wbm_dat_i = $urandom;
        end
        scnt++;
      end else begin
        if (active) begin
          check32("stb_len", 32'(scnt), (cur.delay < TIMEOUT) ? 32'(cur.delay + 1) : 32'(TIMEOUT));
          active = 1'b0;
        end
        bus.wbm_ack_i = ($urandom_range(0, 3) == 0);
        bus.wbm_dat_i = $urandom;
      end
    end
  end

  initial begin : ready_drv
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Response monitor: pops on each handshake, and checks held fields stay put while stalled.
  initial begin : monitor
    rsp_t  e;
    rsp_t  held;
    bit    hold;
    hold = 1'b0;
    held.dat = 32'h0;
    held.err = 1'b0;
    held.last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check32("stall_valid", 32'(bus.rsp_valid), 32'd1);
          check32("stall_dat", bus.rsp_dat, held.dat);
          check32("stall_err", 32'(bus.rsp_err), 32'(held.err));
          check32("stall_last", 32'(bus.rsp_last), 32'(held.last));
        end
        if (bus.rsp_valid) begin
          check32("stb_in_rsp", 32'(bus.wbm_stb_o), 32'd0);
          if (!bus.rsp_last) check32("cyc_burst", 32'(bus.wbm_cyc_o), 32'd1);
          if (bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_rsp actual=dat_%h required=none at %0t", bus.rsp_dat, $time);
            end else begin
              e = exp_q.pop_front();
              check32("rsp_dat", bus.rsp_dat, e.dat);
              check32("rsp_err", 32'(bus.rsp_err), 32'(e.err));
              check32("rsp_last", 32'(bus.rsp_last), 32'(e.last));
            end
            hold = 1'b0;
          end else begin
            hold = 1'b1;
            held.dat = bus.rsp_dat;
            held.err = bus.rsp_err;
            held.last = bus.rsp_last;
          end
        end else begin
          hold = 1'b0;
        end
        if (bus.cmd_ready) begin
          check32("idle_cyc", 32'(bus.wbm_cyc_o), 32'd0);
          check32("idle_stb", 32'(bus.wbm_stb_o), 32'd0);
        end
      end
    end
  end

  initial begin : main
    int n;
    int base;
    logic [31:0] adr;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_adr = 32'h0;
    bus.cmd_dat = 32'h0;
    bus.cmd_sel = 4'h0;
    bus.cmd_len = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check32("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check32("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check32("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("rst_rsp_dat", bus.rsp_dat, 32'd0);
    check32("rst_adr", bus.wbm_adr_o, 32'd0);
    check32("rst_we", 32'(bus.wbm_we_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single write, slave acks two cycles after stb
    ready_pct = 100;
    tb_delay[0] = 2;
    tb_rdat[0] = 32'h5555_AAAA;
    issue_cmd(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 4'd0);
    wait_idle();

    // burst read of four words
    tb_delay[0] = 1; tb_delay[1] = 0; tb_delay[2] = 3; tb_delay[3] = 2;
    tb_rdat[0] = 32'h11; tb_rdat[1] = 32'h22; tb_rdat[2] = 32'h33; tb_rdat[3] = 32'h44;
    issue_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4'd3);
    wait_idle();

    // backpressure: beat 0 held for five cycles
    ready_pct = 0;
    tb_delay[0] = 0; tb_delay[1] = 1;
    tb_rdat[0] = 32'hCAFE_0001; tb_rdat[1] = 32'hCAFE_0002;
    issue_cmd(1'b0, 32'h3000_0100, 32'h0, 4'h3, 4'd1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check32("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    ready_pct = 100;
    wait_idle();

    // timeout on the first beat of a three-beat read
    tb_delay[0] = 100; tb_delay[1] = 0; tb_delay[2] = 0;
    issue_cmd(1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'd2);
    wait_idle();

    // ack on the expiry cycle counts as a normal ack
    tb_delay[0] = TIMEOUT - 1;
    tb_rdat[0] = 32'h0BAD_F00D;
    issue_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 4'd0);
    wait_idle();

    // address wrap
    tb_delay[0] = 0; tb_delay[1] = 1;
    issue_cmd(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'h5, 4'd1);
    wait_idle();

    // reset during beat 1 of a burst
    tb_delay[0] = 0; tb_delay[1] = 6; tb_delay[2] = 0; tb_delay[3] = 0;
    base = beats_started;
    issue_cmd(1'b0, 32'h3000_0400, 32'h0, 4'hF, 4'd3);
    n = 0;
    while (beats_started < base + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check32("rst_burst_beat1", 32'(beats_started), 32'(base + 2));
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    beat_q.delete();
    check32("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check32("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check32("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check32("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    tb_delay[0] = 1; tb_delay[1] = 0;
    tb_rdat[0] = 32'hA1A1_A1A1; tb_rdat[1] = 32'hB2B2_B2B2;
    issue_cmd(1'b0, 32'h3000_0500, 32'h0, 4'hF, 4'd1);
    wait_idle();

    // randomized commands
    for (int k = 0; k < 40; k++) begin
      ready_pct = $urandom_range(30, 100);
      rand_beats(5);
      adr = {$urandom_range(0, 7) == 0 ? 26'h3FF_FFFF : 26'($urandom), 4'($urandom), 2'b00};
      issue_cmd(1'($urandom), adr, $urandom, 4'($urandom), 4'($urandom));
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
